maze_step_ctrl: RTL and testbench
=================================

MAZE_STEP_CTRL -- requirements
Module: maze_step_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ROWS, 6, grid rows.
- COLS, 6, grid columns.
- N_BLOCK, 16, number of blocked-cell slots.
- MAX_STEPS, 64, step limit per trial.
- SW, $clog2(ROWS*COLS+1), state width.
- CW, $clog2(MAX_STEPS+1), counter width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, begin trial (pulse).
- start_state, in, SW, initial cell.
- target_state, in, SW, goal cell.
- blocked, in, N_BLOCK*SW, flattened blocked cells; an entry of 0 is unused.
- action_valid, in, 1, action offered.
- action, in, 2, 0=down(+COLS), 1=right(+1), 2=up(-COLS), 3=left(-1).
- action_ready, out, 1, controller accepts an action.
- move_complete, in, 1, physical move finished (level).
- timer_start, out, 1, one-cycle move-timer launch pulse.
- maze_state, out, SW, current cell.
- next_state, out, SW, latched candidate cell.
- bump, out, 1, last accepted action was rejected.
- target_reached, out, 1, trial ended at goal.
- timeout, out, 1, trial ended on step limit.
- step_count, out, CW, moves committed this trial.
- busy, out, 1, FSM not in IDLE or DONE.

REQ-003 Clock SHALL be clk; reset SHALL be rst, asynchronous, active-high. All outputs SHALL be registered.

Function
REQ-004 Cells SHALL be numbered 1..ROWS*COLS, row-major; cell c SHALL have row (c-1)/COLS and column (c-1)%COLS. Cell 0 SHALL be invalid.

REQ-005 The FSM states SHALL be IDLE, LOAD, READY, WAIT_MOVE, COMMIT and DONE.

REQ-006 IDLE: start=1 SHALL go to LOAD. All other inputs SHALL be ignored.

REQ-007 LOAD SHALL take 1 cycle and then go to READY.
- maze_state SHALL be set to start_state if it is in 1..ROWS*COLS, else to 1.
- step_count, bump, target_reached and timeout SHALL be cleared.
- If the loaded cell equals target_state, the next state SHALL be DONE with target_reached=1 instead.

REQ-008 READY: action_ready SHALL be 1. action_valid=1 SHALL latch next_state, set bump, pulse timer_start for exactly 1 cycle, and go to WAIT_MOVE. Transfer SHALL occur on action_valid&action_ready.

REQ-009 A candidate SHALL be legal only when all of the following hold; otherwise next_state SHALL equal maze_state and bump=1, else bump=0:
- down: row < ROWS-1.
- up: row > 0.
- right: column < COLS-1.
- left: column > 0.
- the candidate matches no nonzero blocked entry.

REQ-010 Candidate arithmetic SHALL use SW+1 bits so that no wrap-around occurs. Columns SHALL NOT wrap into adjacent rows.

REQ-011 WAIT_MOVE SHALL hold until move_complete=1, then go to COMMIT. action_ready SHALL be 0 in this state. timer_start SHALL NOT re-pulse.

REQ-012 COMMIT SHALL take 1 cycle: maze_state <= next_state and step_count += 1 (a bumped move also counts). The next state SHALL then be:
- DONE with target_reached=1 if the new maze_state == target_state;
- else DONE with timeout=1 if step_count+1 == MAX_STEPS;
- else READY.
If both conditions hold, target_reached SHALL win and timeout SHALL stay 0.

REQ-013 DONE SHALL hold all outputs. start=1 SHALL go to LOAD (restart). busy SHALL be 0 in DONE.

REQ-014 A start asserted in LOAD, READY, WAIT_MOVE or COMMIT SHALL be ignored.

REQ-015 blocked and target_state SHALL be sampled live each cycle. start_state SHALL be sampled only in LOAD.

Reset
REQ-016 On rst=1, asynchronously and at any state including mid-move:
- the FSM SHALL go to IDLE;
- maze_state, next_state and step_count SHALL be 0;
- action_ready, timer_start, bump, target_reached, timeout and busy SHALL be 0.

REQ-017 After rst deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-018 Defaults, start_state=1, target=3, no blocks: action 1, move_complete; action 1, move_complete -> maze_state 2 then 3, step_count=2, target_reached=1, busy=0.

REQ-019 maze_state=6, action 1 -> bump=1, next_state=6, and after the commit maze_state=6, step_count=1. Likewise maze_state=7, action 3 -> bump=1 (no wrap to 6).

REQ-020 blocked[0]=8, maze_state=2, action 0 -> bump=1, maze_state stays 2. With blocked[0]=0, the same action -> maze_state=8.

REQ-021 MAX_STEPS=4, target unreachable, 4 accepted actions -> timeout=1 on the 4th commit, step_count=4, and further action_valid is not accepted.

REQ-022 rst pulsed during WAIT_MOVE -> all outputs 0 immediately. Then start with start_state=0 -> maze_state=1.

REQ-023 start_state == target_state=15 -> DONE after LOAD, target_reached=1, step_count=0, timer_start never pulses.

Source files
------------

// File: rtl/maze_step_ctrl.sv
// Step controller for a grid-maze agent: accepts one move per trial step, checks
// it against the grid edges and blocked cells, and commits it once the move finishes.
module maze_step_ctrl #(
    parameter int ROWS      = 6,
    parameter int COLS      = 6,
    parameter int N_BLOCK   = 16,
    parameter int MAX_STEPS = 64,
    parameter int SW        = $clog2(ROWS*COLS+1),
    parameter int CW        = $clog2(MAX_STEPS+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SW-1:0]         start_state,
    input  logic [SW-1:0]         target_state,
    input  logic [N_BLOCK*SW-1:0] blocked,
    input  logic                  action_valid,
    input  logic [1:0]            action,
    output logic                  action_ready,
    input  logic                  move_complete,
    output logic                  timer_start,
    output logic [SW-1:0]         maze_state,
    output logic [SW-1:0]         next_state,
    output logic                  bump,
    output logic                  target_reached,
    output logic                  timeout,
    output logic [CW-1:0]         step_count,
    output logic                  busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StReady,
        StWaitMove,
        StCommit,
        StDone
    } state_t;

    localparam logic [SW-1:0] L_NCELLS    = SW'(ROWS*COLS);
    localparam logic [SW-1:0] L_COLS      = SW'(COLS);
    localparam logic [SW-1:0] L_ROW_MAX   = SW'(ROWS-1);
    localparam logic [SW-1:0] L_COL_MAX   = SW'(COLS-1);
    localparam logic [SW:0]   L_ROW_STEP  = (SW+1)'(COLS);
    localparam logic [SW:0]   L_ONE       = (SW+1)'(1);
    localparam logic [CW-1:0] L_MAX_STEPS = CW'(MAX_STEPS);

    state_t        r_state;
    logic [SW-1:0] r_maze_state;
    logic [SW-1:0] r_next_state;
    logic [CW-1:0] r_step_count;
    logic          r_action_ready;
    logic          r_timer_start;
    logic          r_bump;
    logic          r_target_reached;
    logic          r_timeout;
    logic          r_busy;

    logic [SW-1:0] w_idx;
    logic [SW-1:0] w_row;
    logic [SW-1:0] w_col;
    logic [SW:0]   w_cur;
    logic [SW:0]   w_cand;
    logic          w_dir_ok;
    logic          w_hit;
    logic          w_legal;
    logic [SW-1:0] w_next;
    logic [SW-1:0] w_load_cell;
    logic [CW-1:0] w_steps_inc;

    // Candidate is formed one bit wider than a cell index so edge moves never wrap.
    always_comb begin
        w_idx    = r_maze_state - SW'(1);
        w_row    = w_idx / L_COLS;
        w_col    = w_idx % L_COLS;
        w_cur    = {1'b0, r_maze_state};
        w_cand   = w_cur;
        w_dir_ok = 1'b0;
        unique case (action)
            2'd0: begin
                w_dir_ok = (w_row < L_ROW_MAX);
                w_cand   = w_cur + L_ROW_STEP;
            end
            2'd1: begin
                w_dir_ok = (w_col < L_COL_MAX);
                w_cand   = w_cur + L_ONE;
            end
            2'd2: begin
                w_dir_ok = (w_row != '0);
                w_cand   = w_cur - L_ROW_STEP;
            end
            default: begin
                w_dir_ok = (w_col != '0);
                w_cand   = w_cur - L_ONE;
            end
        endcase

        w_hit = 1'b0;
        for (int i = 0; i < N_BLOCK; i++) begin
            if (blocked[i*SW +: SW] != '0 && {1'b0, blocked[i*SW +: SW]} == w_cand) begin
                w_hit = 1'b1;
            end
        end

        w_legal     = w_dir_ok && !w_hit;
        w_next      = w_legal ? w_cand[SW-1:0] : r_maze_state;
        w_load_cell = (start_state != '0 && start_state <= L_NCELLS) ? start_state : SW'(1);
        w_steps_inc = r_step_count + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= StIdle;
            r_maze_state     <= '0;
            r_next_state     <= '0;
            r_step_count     <= '0;
            r_action_ready   <= 1'b0;
            r_timer_start    <= 1'b0;
            r_bump           <= 1'b0;
            r_target_reached <= 1'b0;
            r_timeout        <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_timer_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state <= StLoad;
                        r_busy  <= 1'b1;
                    end
                end
                StLoad: begin
                    r_maze_state <= w_load_cell;
                    r_step_count <= '0;
                    r_bump       <= 1'b0;
                    r_timeout    <= 1'b0;
                    if (w_load_cell == target_state) begin
                        r_target_reached <= 1'b1;
                        r_busy           <= 1'b0;
                        r_state          <= StDone;
                    end else begin
                        r_target_reached <= 1'b0;
                        r_action_ready   <= 1'b1;
                        r_state          <= StReady;
                    end
                end
                StReady: begin
                    if (action_valid && r_action_ready) begin
                        r_next_state   <= w_next;
                        r_bump         <= !w_legal;
                        r_timer_start  <= 1'b1;
                        r_action_ready <= 1'b0;
                        r_state        <= StWaitMove;
                    end
                end
                StWaitMove: begin
                    if (move_complete) begin
                        r_state <= StCommit;
                    end
                end
                StCommit: begin
                    r_maze_state <= r_next_state;
                    r_step_count <= w_steps_inc;
                    // Reaching the goal on the last allowed step counts as success.
                    if (r_next_state == target_state) begin
                        r_target_reached <= 1'b1;
                        r_busy           <= 1'b0;
                        r_state          <= StDone;
                    end else if (w_steps_inc == L_MAX_STEPS) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= StDone;
                    end else begin
                        r_action_ready <= 1'b1;
                        r_state        <= StReady;
                    end
                end
                StDone: begin
                    if (start) begin
                        r_state <= StLoad;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= StIdle;
                    r_action_ready <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign action_ready   = r_action_ready;
    assign timer_start    = r_timer_start;
    assign maze_state     = r_maze_state;
    assign next_state     = r_next_state;
    assign bump           = r_bump;
    assign target_reached = r_target_reached;
    assign timeout        = r_timeout;
    assign step_count     = r_step_count;
    assign busy           = r_busy;

endmodule

// File: tb/tb_maze_step_ctrl.sv
// Bench for maze_step_ctrl: directed scenarios plus random trials, all checked
// against a row/column grid model of the maze held in the bench.
module tb_maze_step_ctrl;

    localparam int ROWS      = 6;
    localparam int COLS      = 6;
    localparam int N_BLOCK   = 16;
    localparam int MAX_STEPS = 64;
    localparam int SW        = $clog2(ROWS*COLS+1);
    localparam int CW        = $clog2(MAX_STEPS+1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [SW-1:0]         start_state;
    logic [SW-1:0]         target_state;
    logic [N_BLOCK*SW-1:0] blocked;
    logic                  action_valid;
    logic [1:0]            action;
    logic                  action_ready;
    logic                  move_complete;
    logic                  timer_start;
    logic [SW-1:0]         maze_state;
    logic [SW-1:0]         next_state;
    logic                  bump;
    logic                  target_reached;
    logic                  timeout;
    logic [CW-1:0]         step_count;
    logic                  busy;

    maze_step_ctrl #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .N_BLOCK   (N_BLOCK),
        .MAX_STEPS (MAX_STEPS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_state    (start_state),
        .target_state   (target_state),
        .blocked        (blocked),
        .action_valid   (action_valid),
        .action         (action),
        .action_ready   (action_ready),
        .move_complete  (move_complete),
        .timer_start    (timer_start),
        .maze_state     (maze_state),
        .next_state     (next_state),
        .bump           (bump),
        .target_reached (target_reached),
        .timeout        (timeout),
        .step_count     (step_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int blk [N_BLOCK];
    int m_state;
    int m_target;
    int m_steps;
    bit m_done;
    bit m_tr;
    bit m_to;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_blocked();
        for (int i = 0; i < N_BLOCK; i++) blocked[i*SW +: SW] = SW'(blk[i]);
    endtask

    // Cell reached by action a from cell s, or -1 when the move is rejected.
    function automatic int cand_of(input int s, input int a);
        int r = (s - 1) / COLS;
        int c = (s - 1) % COLS;
        int n;
        case (a)
            0:       n = (r < ROWS - 1) ? s + COLS : -1;
            1:       n = (c < COLS - 1) ? s + 1    : -1;
            2:       n = (r > 0)        ? s - COLS : -1;
            default: n = (c > 0)        ? s - 1    : -1;
        endcase
        for (int i = 0; i < N_BLOCK; i++)
            if (n != -1 && blk[i] != 0 && blk[i] == n) n = -1;
        return n;
    endfunction

    task automatic check_zero(input string tag);
        check_eq({tag, "_ready"}, action_ready, 0);
        check_eq({tag, "_timer"}, timer_start, 0);
        check_eq({tag, "_state"}, maze_state, 0);
        check_eq({tag, "_next"}, next_state, 0);
        check_eq({tag, "_bump"}, bump, 0);
        check_eq({tag, "_tr"}, target_reached, 0);
        check_eq({tag, "_to"}, timeout, 0);
        check_eq({tag, "_steps"}, step_count, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("rst");
        tick();
        rst = 1'b0;
        tick();
        m_state = 0;
        m_steps = 0;
        m_done  = 1'b0;
    endtask

    task automatic start_trial(input int s, input int t);
        start_state  = SW'(s);
        target_state = SW'(t);
        m_target     = t;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        check_eq("load_busy", busy, 1);
        tick();
        m_state = (s >= 1 && s <= ROWS * COLS) ? s : 1;
        m_steps = 0;
        m_tr    = (m_state == t);
        m_to    = 1'b0;
        m_done  = m_tr;
        check_eq("load_state", maze_state, m_state);
        check_eq("load_steps", step_count, 0);
        check_eq("load_tr", target_reached, m_tr);
        check_eq("load_to", timeout, 0);
        check_eq("load_busy2", busy, !m_done);
        check_eq("load_ready", action_ready, !m_done);
    endtask

    task automatic do_step(input int a, input int wait_cyc, input bit poke_start);
        int  n    = cand_of(m_state, a);
        bit  bmp  = (n == -1);
        int  prev = m_state;
        if (bmp) n = m_state;
        check_eq("step_ready", action_ready, 1);
        action_valid = 1'b1;
        action       = 2'(a);
        tick();
        action_valid = 1'b0;
        check_eq("acc_timer", timer_start, 1);
        check_eq("acc_next", next_state, n);
        check_eq("acc_bump", bump, bmp);
        check_eq("acc_ready", action_ready, 0);
        check_eq("acc_state", maze_state, prev);
        for (int k = 0; k < wait_cyc; k++) begin
            start        = poke_start;
            action_valid = 1'($urandom_range(0, 1));
            tick();
            check_eq("wait_timer", timer_start, 0);
            check_eq("wait_ready", action_ready, 0);
        end
        start         = 1'b0;
        action_valid  = 1'b0;
        move_complete = 1'b1;
        tick();
        move_complete = 1'b0;
        tick();
        m_state = n;
        m_steps++;
        if (m_state == m_target) m_tr = 1'b1;
        else if (m_steps == MAX_STEPS) m_to = 1'b1;
        m_done = m_tr || m_to;
        check_eq("cmt_state", maze_state, m_state);
        check_eq("cmt_steps", step_count, m_steps);
        check_eq("cmt_tr", target_reached, m_tr);
        check_eq("cmt_to", timeout, m_to);
        check_eq("cmt_busy", busy, !m_done);
        check_eq("cmt_ready", action_ready, !m_done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        start_state   = '0;
        target_state  = '0;
        action_valid  = 1'b0;
        action        = '0;
        move_complete = 1'b0;
        for (int i = 0; i < N_BLOCK; i++) blk[i] = 0;
        set_blocked();
        tick();
        do_reset();
        repeat (3) tick();
        check_eq("idle_busy", busy, 0);
        check_eq("idle_ready", action_ready, 0);

        // Two steps right from cell 1 reach goal 3.
        start_trial(1, 3);
        do_step(1, 1, 1'b0);
        check_eq("r18_s1", maze_state, 2);
        do_step(1, 0, 1'b0);
        check_eq("r18_state", maze_state, 3);
        check_eq("r18_steps", step_count, 2);
        check_eq("r18_tr", target_reached, 1);
        check_eq("r18_busy", busy, 0);

        // Start already on the goal.
        start_trial(15, 15);
        check_eq("r23_tr", target_reached, 1);
        check_eq("r23_steps", step_count, 0);
        action_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("r23_timer", timer_start, 0);
            check_eq("r23_hold", maze_state, 15);
        end
        action_valid = 1'b0;

        // Edge bumps: no wrap across row boundaries.
        start_trial(6, 36);
        do_step(1, 0, 1'b0);
        check_eq("r19_bump", bump, 1);
        check_eq("r19_next", next_state, 6);
        check_eq("r19_steps", step_count, 1);
        do_reset();
        start_trial(7, 36);
        do_step(3, 0, 1'b0);
        check_eq("r19b_bump", bump, 1);
        check_eq("r19b_state", maze_state, 7);
        do_reset();

        // Blocked cell, then the block is removed live.
        blk[0] = 8;
        set_blocked();
        start_trial(2, 36);
        do_step(0, 0, 1'b0);
        check_eq("r20_bump", bump, 1);
        check_eq("r20_state", maze_state, 2);
        blk[0] = 0;
        set_blocked();
        do_step(0, 0, 1'b0);
        check_eq("r20_state2", maze_state, 8);
        do_reset();

        // Unreachable goal runs into the step limit.
        start_trial(1, 0);
        for (int k = 0; k < MAX_STEPS; k++)
            do_step($urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
        check_eq("r21_to", timeout, 1);
        check_eq("r21_steps", step_count, MAX_STEPS);
        check_eq("r21_tr", target_reached, 0);
        action_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("r21_timer", timer_start, 0);
            check_eq("r21_ready", action_ready, 0);
            check_eq("r21_hold", step_count, MAX_STEPS);
        end
        action_valid = 1'b0;

        // Reset in the middle of a move, then an invalid start cell.
        start_trial(5, 36);
        action_valid = 1'b1;
        action       = 2'd0;
        tick();
        action_valid = 1'b0;
        check_eq("r22_timer", timer_start, 1);
        do_reset();
        repeat (3) tick();
        check_eq("r22_idle", busy, 0);
        check_eq("r22_idle_state", maze_state, 0);
        start_trial(0, 20);
        check_eq("r22_state", maze_state, 1);
        do_reset();

        // Random trials.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N_BLOCK; i++) blk[i] = 0;
            for (int i = 0; i < 4; i++) blk[$urandom_range(0, N_BLOCK - 1)] = $urandom_range(0, 36);
            set_blocked();
            start_trial($urandom_range(0, 40), $urandom_range(1, 36));
            while (!m_done)
                do_step($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
